ccff_chain_loader: RTL
======================

# ccff_chain_loader

Sequencer that loads a configuration-flip-flop (ccff) chain through the fabric's programming port. A host supplies bitstream words over a valid/ready stream. The block serializes them onto `ccff_head` and drives the shift enable for the chain's programming clock gate. When requested, it runs a second identical pass and compares `ccff_tail` against `ccff_head` to confirm the chain holds the intended configuration. It sits between the bitstream source and the `ccff_head`/`ccff_tail` ends of the switch-block and connection-block memory chain.

## Interface
Parameters:
- `CHAIN_LEN`, default 64: number of configuration bits in the chain (≥1).
- `WORD_W`, default 8: width of host bitstream words (≥1).

Ports:
- `prog_clk`  in  1  programming clock. One clock domain only. Reset is asynchronous and active-low.
- `prog_reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a programming sequence; sampled only in IDLE.
- `verify_en`  in  1  sampled together with `start`; 1 selects load plus verify pass.
- `abort`  in  1  cancel the sequence and return to IDLE.
- `cfg_data`  in  WORD_W  bitstream word; LSB is shifted first.
- `cfg_valid`  in  1  `cfg_data` is valid.
- `cfg_ready`  out  1  block accepts `cfg_data` this cycle.
- `ccff_head`  out  1  serial configuration bit to the chain.
- `chain_clk_en`  out  1  enable for the external clock gate on the chain's `prog_clk`.
- `ccff_tail`  in  1  serial output of the chain.
- `busy`  out  1  sequence in progress.
- `done`  out  1  sequence completed; held until the next `start`.
- `error`  out  1  verify mismatch seen; sticky until the next `start`.
- `err_idx`  out  $clog2(CHAIN_LEN)  bit index of the first mismatch.

## Operation
- States:
  - IDLE: waits for `start`.
  - LOAD: first pass.
  - VERIFY: second pass.
  - DONE: sequence complete.
- IDLE→LOAD on `start`; `verify_en` is latched at this point. On the same transition, `done`, `error` and `err_idx` clear to 0.
- Word buffer behaviour:
  - Holds up to WORD_W bits.
  - `ccff_head` = buffer bit 0.
  - `chain_clk_en` = 1 whenever the buffer is non-empty in LOAD or VERIFY.
  - Every enabled cycle shifts the buffer right by one and increments `bit_cnt`.
- Words per pass = ceil(CHAIN_LEN/WORD_W). For the final word, only the low CHAIN_LEN mod WORD_W bits are shifted (all bits if that remainder is 0); the upper bits are discarded.
- `cfg_ready` = 1 when all of the following hold:
  - state is LOAD or VERIFY;
  - words remain in the current pass;
  - the buffer is empty, or holds exactly 1 bit being shifted this cycle.
  
  This allows a gapless stream.
- Pass end: when `bit_cnt` reaches CHAIN_LEN, the block does the following:
  - Resets `bit_cnt` to 0.
  - In LOAD with verify latched, goes to VERIFY.
  - Otherwise goes to DONE.
- VERIFY:
  - The host resends the identical stream.
  - On each enabled cycle, `ccff_tail` is compared with `ccff_head`. Before shift k of pass 2, the tail holds pass-1 bit k.
  - On the first mismatch, `err_idx` = `bit_cnt` and `error` = 1. Later mismatches leave `err_idx` unchanged.
- DONE:
  - `done` = 1 and `busy` = 0.
  - Goes to IDLE on the next cycle; `done` stays held.
- `abort` in LOAD or VERIFY:
  - Next state is IDLE; buffer and counters clear.
  - `done` stays 0. Chain contents are undefined.
  - `abort` has priority over a simultaneous pass end.
- `start` while busy is ignored. `cfg_valid` outside LOAD/VERIFY is ignored (`cfg_ready` = 0).
- Reset values: state IDLE; `cfg_ready`, `chain_clk_en`, `ccff_head`, `busy`, `done`, `error`, `err_idx` all 0.

## Timing
- Handshake completes at a `prog_clk` edge where `cfg_valid`&&`cfg_ready`. The word loads into the buffer at that edge.
- Bit 0 of an accepted word appears on `ccff_head` with `chain_clk_en` = 1 in the cycle after acceptance. The chain captures it at the following edge. Latency is 1 cycle.
- A pass with a gapless host takes CHAIN_LEN enabled cycles plus 1 initial cycle. The pass-to-pass boundary adds no bubble.
- `busy` is high from the edge after `start` until the edge entering DONE.
- `chain_clk_en` and `ccff_head` come only from registered state, with no combinational path from inputs, so the clock gate sees a glitch-free enable.
- `cfg_valid` deasserting mid-pass stalls shifting: `chain_clk_en` = 0 and `bit_cnt` holds.
- Async reset asserted mid-pass: `chain_clk_en` drops to 0 immediately, without waiting for a clock edge.

## Structure
- Package `ccff_loader_pkg` holds:
  - the state enum (IDLE, LOAD, VERIFY, DONE);
  - localparam functions for words-per-pass and last-word bit count;
  - counter width helpers.
- Sub-module `ccff_word_serializer` holds the buffer, the bits-remaining count, `cfg_ready` generation and `ccff_head`. The top level holds the FSM, `bit_cnt`, the pass logic, the comparator and the error capture.

## Test plan
Bench settings: CHAIN_LEN=10, WORD_W=4, with a shift-register chain model.
- Load without verify, words 0x5, 0xA, 0x3 gapless:
  - exactly 10 `chain_clk_en` cycles;
  - chain holds 1010010111 (first bit deepest);
  - `done` = 1 and `error` = 0.
- Load with verify using the same stream sent twice:
  - 20 enabled cycles;
  - `error` = 0 and `done` = 1.
- Verify with bit 6 flipped in pass 2:
  - `error` = 1 and `err_idx` = 6;
  - `done` = 1.
- `cfg_valid` low for 3 cycles mid-word:
  - `chain_clk_en` is 0 for those cycles;
  - final chain contents are unchanged from the gapless case.
- `abort` at bit 5 of LOAD:
  - IDLE on the next cycle, `done` = 0, `cfg_ready` = 0;
  - a new `start` begins at `bit_cnt` = 0.
- `prog_reset_n` pulsed low mid-VERIFY:
  - all outputs go to 0 asynchronously;
  - `start` during `busy` is ignored, checked in a separate run.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the ccff chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DONE
  } state_e;

  function automatic int words_per_pass(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // The final word carries only the bits needed to fill the chain.
  function automatic int last_word_bits(input int chain_len, input int word_w);
    return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int max_val);
    return idx_w(max_val + 1);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Host bitstream stream: one word per cfg_valid && cfg_ready edge.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_word_serializer.sv
// Word buffer that shifts host words LSB-first onto ccff_head and paces the stream handshake.
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic              arm,
  input  logic              clear,
  input  logic              rearm,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              shift_en
);

  localparam int WPP  = words_per_pass(CHAIN_LEN, WORD_W);
  localparam int LAST = last_word_bits(CHAIN_LEN, WORD_W);
  localparam int CW   = cnt_w(WORD_W);
  localparam int WW   = cnt_w(WPP);

  logic [WORD_W-1:0] shreg;
  logic [CW-1:0]     bits_left;
  logic [WW-1:0]     words_left;
  logic [WW-1:0]     words_eff;
  logic              fire;

  // A word taken on the last bit of the load pass belongs to the verify pass.
  assign words_eff = (words_left == '0) ? WW'(WPP) : words_left;
  assign shift_en  = active && (bits_left != '0);
  assign cfg_ready = active && ((words_left != '0) || rearm) && (bits_left <= CW'(1));
  assign fire      = cfg_valid && cfg_ready;
  assign ccff_head = shreg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bits_left  <= '0;
      words_left <= '0;
    end else if (clear) begin
      shreg      <= '0;
      bits_left  <= '0;
      words_left <= '0;
    end else if (arm) begin
      words_left <= WW'(WPP);
    end else if (fire) begin
      shreg      <= cfg_data;
      bits_left  <= (words_eff == WW'(1)) ? CW'(LAST) : CW'(WORD_W);
      words_left <= words_eff - WW'(1);
    end else begin
      if (shift_en) begin
        shreg     <= shreg >> 1;
        bits_left <= bits_left - CW'(1);
      end
      if (rearm) begin
        words_left <= WW'(WPP);
      end
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Sequencer for loading and optionally read-back verifying a ccff configuration chain.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic                           prog_clk,
  input  logic                           prog_reset_n,
  input  logic                           start,
  input  logic                           verify_en,
  input  logic                           abort,
  ccff_chain_loader_if.slave             cfg,
  output logic                           ccff_head,
  output logic                           chain_clk_en,
  input  logic                           ccff_tail,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [idx_w(CHAIN_LEN)-1:0]    err_idx
);

  localparam int IW = idx_w(CHAIN_LEN);

  state_e        state;
  logic          vfy_q;
  logic [IW-1:0] bit_cnt;
  logic          active;
  logic          shift_en;
  logic          pass_end;
  logic          rearm;
  logic          arm;
  logic          clear;
  logic          mismatch;

  assign active   = (state == S_LOAD) || (state == S_VERIFY);
  assign pass_end = shift_en && (bit_cnt == IW'(CHAIN_LEN - 1));
  assign rearm    = pass_end && (state == S_LOAD) && vfy_q;
  assign arm      = (state == S_IDLE) && start;
  assign clear    = active && abort;
  assign mismatch = (state == S_VERIFY) && shift_en && (ccff_tail != ccff_head);

  // Clock-gate enable decodes registered state only, so it cannot glitch on host inputs.
  assign chain_clk_en = shift_en;

  ccff_word_serializer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_ser (
    .clk       (prog_clk),
    .rst_n     (prog_reset_n),
    .active    (active),
    .arm       (arm),
    .clear     (clear),
    .rearm     (rearm),
    .cfg_data  (cfg.cfg_data),
    .cfg_valid (cfg.cfg_valid),
    .cfg_ready (cfg.cfg_ready),
    .ccff_head (ccff_head),
    .shift_en  (shift_en)
  );

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state   <= S_IDLE;
      vfy_q   <= 1'b0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      err_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_LOAD;
            vfy_q   <= verify_en;
            bit_cnt <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            error   <= 1'b0;
            err_idx <= '0;
          end
        end
        S_LOAD, S_VERIFY: begin
          if (abort) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            busy    <= 1'b0;
          end else begin
            // Only the first mismatch position is kept.
            if (mismatch && !error) begin
              error   <= 1'b1;
              err_idx <= bit_cnt;
            end
            if (pass_end) begin
              bit_cnt <= '0;
              if (rearm) begin
                state <= S_VERIFY;
              end else begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else if (shift_en) begin
              bit_cnt <= bit_cnt + IW'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
